// File: rtl/seq_signed_divider_pkg.sv
// Shared state encoding and default widths for the sequential signed divider.
package seq_signed_divider_pkg;
  localparam int DW_DEF = 12;
  localparam int VW_DEF = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/seq_signed_divider_if.sv
// start/busy/done handshake plus operand and result buses of the divider.
interface seq_signed_divider_if #(
  parameter int DW = seq_signed_divider_pkg::DW_DEF,
  parameter int VW = seq_signed_divider_pkg::VW_DEF
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;
  logic          ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/seq_signed_divider_div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module seq_signed_divider_div_step #(
  parameter int VW = 6
) (
  input  logic [VW-1:0] i_p,
  input  logic          i_bit,
  input  logic [VW-1:0] i_d,
  output logic [VW-1:0] o_p,
  output logic          o_q
);
  logic [VW:0] w_shift;

  // The held remainder is always below |d| <= 2^(VW-1), so the
  // difference always fits back into VW bits.
  assign w_shift = {i_p, i_bit};
  assign o_q     = (w_shift >= {1'b0, i_d});
  assign o_p     = o_q ? VW'(w_shift - {1'b0, i_d}) : w_shift[VW-1:0];
endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: one quotient bit per clock, sign fix-up at the end.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input logic                clk,
  input logic                rst,
  seq_signed_divider_if.slave bus
);
  localparam int CW = $clog2(DW + 1);

  state_t r_state, w_state_nxt;

  logic [VW-1:0] r_p;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_d;
  logic [CW-1:0] r_cnt;
  logic          r_sq, r_sr, r_zdiv, r_ovf_pend;
  logic          r_busy, r_done, r_dbz, r_ovf;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem;

  logic          w_load, w_step, w_fix, w_last;
  logic [DW-1:0] w_a_mag;
  logic [VW-1:0] w_b_mag;
  logic [VW-1:0] w_p_nxt;
  logic          w_qbit;

  assign w_a_mag = bus.dividend[DW-1] ? DW'(-bus.dividend) : bus.dividend;
  assign w_b_mag = bus.divisor[VW-1]  ? VW'(-bus.divisor)  : bus.divisor;
  assign w_last  = (r_cnt == CW'(DW - 1));

  seq_signed_divider_div_step #(.VW(VW)) u_step (
    .i_p   (r_p),
    .i_bit (r_q[DW-1]),
    .i_d   (r_d),
    .o_p   (w_p_nxt),
    .o_q   (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = (bus.divisor == '0) ? S_FIX : S_ITER;
      S_ITER:  if (w_last)    w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      S_IDLE:  w_load = bus.start;
      S_ITER:  w_step = 1'b1;
      S_FIX:   w_fix  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p        <= '0;
      r_q        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_sq       <= 1'b0;
      r_sr       <= 1'b0;
      r_zdiv     <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_p        <= '0;
        r_q        <= w_a_mag;
        r_d        <= w_b_mag;
        r_cnt      <= '0;
        r_sq       <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
        r_sr       <= bus.dividend[DW-1];
        r_zdiv     <= (bus.divisor == '0);
        r_ovf_pend <= (bus.dividend == {1'b1, {(DW-1){1'b0}}}) && (bus.divisor == '1);
        r_busy     <= 1'b1;
        r_dbz      <= 1'b0;
        r_ovf      <= 1'b0;
      end
      if (w_step) begin
        r_p   <= w_p_nxt;
        r_q   <= {r_q[DW-2:0], w_qbit};
        r_cnt <= CW'(r_cnt + 1'b1);
      end
      // -2^(DW-1)/-1 needs no special path: the magnitude 2^(DW-1) wraps back to itself.
      if (w_fix) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_dbz  <= r_zdiv;
        r_ovf  <= r_ovf_pend;
        if (r_zdiv) begin
          r_quot <= '1;
          r_rem  <= '0;
        end else begin
          r_quot <= r_sq ? DW'(-r_q) : r_q;
          r_rem  <= r_sr ? VW'(-r_p) : r_p;
        end
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.dbz       = r_dbz;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and random checks of the sequential signed divider.
module tb_seq_signed_divider;
  import seq_signed_divider_pkg::*;
  localparam int DW = DW_DEF;
  localparam int VW = VW_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_signed_divider_if #(.DW(DW), .VW(VW)) bus ();
  seq_signed_divider #(.DW(DW), .VW(VW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic chk_res(input string tag, input int eq, input int er,
                         input logic edbz, input logic eovf);
    logic [DW-1:0] q_e;
    logic [VW-1:0] r_e;
    q_e = DW'(eq);
    r_e = VW'(er);
    chk({tag, ".q"},    32'(bus.quotient),  32'(q_e));
    chk({tag, ".r"},    32'(bus.remainder), 32'(r_e));
    chk({tag, ".dbz"},  32'(bus.dbz),  32'(edbz));
    chk({tag, ".ovf"},  32'(bus.ovf),  32'(eovf));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(0));
  endtask

  task automatic div(input string tag, input int a, input int b, input int eq, input int er,
                     input logic edbz, input logic eovf, input int lat);
    issue(DW'(a), VW'(b));
    chk({tag, ".acc"}, {30'(0), bus.busy, bus.done}, 32'h2);
    wait_done(tag, lat);
    chk_res(tag, eq, er, edbz, eovf);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(bus.done), 32'(0));
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", {26'(0), bus.busy, bus.done, bus.dbz, bus.ovf, 2'b00}, 32'(0));
    chk("rst.q", 32'(bus.quotient), 32'(0));
    chk("rst.r", 32'(bus.remainder), 32'(0));
    rst = 1'b0;

    div("p_p", 100, 7, 14, 2, 1'b0, 1'b0, 13);
    div("n_p", -100, 7, -14, -2, 1'b0, 1'b0, 13);
    div("p_n", 100, -7, -14, 2, 1'b0, 1'b0, 13);
    div("n_n", -100, -7, 14, -2, 1'b0, 1'b0, 13);
    div("ovf", -2048, -1, -2048, 0, 1'b0, 1'b1, 13);
    div("minneg", -2048, -32, 64, 0, 1'b0, 1'b0, 13);
    div("dbz", 5, 0, -1, 0, 1'b1, 1'b0, 1);
    div("after_dbz", 6, 3, 2, 0, 1'b0, 1'b0, 13);
    div("maxpos", 2047, 31, 66, 1, 1'b0, 1'b0, 13);

    // start while busy is dropped; start in the done cycle is taken
    issue(DW'(77), VW'(5));
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = DW'(9); bus.divisor = VW'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("ign", 9);
    chk_res("ign", 15, 2, 1'b0, 1'b0);
    bus.start = 1'b1; bus.dividend = DW'(9); bus.divisor = VW'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b.acc", {30'(0), bus.busy, bus.done}, 32'h2);
    wait_done("b2b", 13);
    chk_res("b2b", 3, 0, 1'b0, 1'b0);

    // reset mid-operation
    issue(DW'(1000), VW'(9));
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.state", {26'(0), bus.busy, bus.done, bus.dbz, bus.ovf, 2'b00}, 32'(0));
    chk("abort.q", 32'(bus.quotient), 32'(0));
    chk("abort.r", 32'(bus.remainder), 32'(0));
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      chk("abort.quiet", 32'(seen), 32'(0));
    end
    div("after_abort", 1000, 9, 111, 1, 1'b0, 1'b0, 13);

    for (int i = 0; i < 30; i++) begin
      logic [DW-1:0] a12;
      logic [VW-1:0] b6;
      int sa, sb;
      a12 = DW'($urandom_range(0, (1 << DW) - 1));
      b6  = VW'($urandom_range(1, (1 << VW) - 1));
      if (i == 0) begin a12 = {1'b1, {(DW-1){1'b0}}}; b6 = '1; end
      sa = int'($signed(a12));
      sb = int'($signed(b6));
      div("rnd", sa, sb, sa / sb, sa % sb, 1'b0, (sa == -(1 << (DW-1))) && (sb == -1), 13);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
